// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S receiver for the WM8731 ADC stream feeding the pedal board.
// Synchronizes BCLK/LRCK/DATA into Clk, deserializes one channel per frame
// MSB first, and emits a registered sample with a one-cycle valid strobe.
// Optional feature macro: AUDIO_RX_MONO_MIX_EN (output the average of left and right).
module audio_adc_rx #(
  parameter int WIDTH   = 16,
  parameter int CHANNEL = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             AUD_BCLK,
  input  logic             AUD_ADCLRCK,
  input  logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] Signal_in,
  output logic             Sample_valid,
  output logic             Frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  state_t state;
  state_t next_state;

  // [0] and [1] form the synchronizer; [2] is the previous synced value for edge detection
  logic [2:0] bclk_sync;
  logic [2:0] lrck_sync;
  logic [1:0] data_sync;

  logic bclk_rise;
  logic lr_edge;
  logic data_bit;

  logic             channel;
  logic [CW-1:0]    bit_count;
  logic [WIDTH-2:0] shift_reg;
  logic [WIDTH-1:0] word;

  logic start_word;
  logic shift_en;
  logic word_done;
  logic short_err;

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lr_edge   = lrck_sync[1] ^ lrck_sync[2];
  assign data_bit  = data_sync[1];
  assign word      = {shift_reg, data_bit};

  // Bring the asynchronous codec pins into the Clk domain
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[1:0], AUD_ADCLRCK};
      data_sync <= {data_sync[0], AUD_ADCDAT};
    end
  end

  // Remember which channel the current half-frame belongs to
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      channel <= 1'b0;
    end else if (lr_edge) begin
      channel <= lrck_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; an LRCK edge always wins over a coincident BCLK rise
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lr_edge) next_state = SKIP;
      SKIP:    if (!lr_edge && bclk_rise) next_state = SHIFT;
      SHIFT: begin
        if (lr_edge) begin
          next_state = SKIP;
        end else if (word_done) begin
          next_state = HOLD;
        end
      end
      HOLD:    if (lr_edge) next_state = SKIP;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from state and synced events
  always_comb begin
    start_word = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    short_err  = 1'b0;
    case (state)
      SKIP: start_word = bclk_rise && !lr_edge;
      SHIFT: begin
        shift_en  = bclk_rise && !lr_edge;
        word_done = shift_en && (bit_count == CW'(WIDTH - 1));
        short_err = lr_edge;
      end
      default: ;
    endcase
  end

  // Bit counter and MSB-first shift register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_count <= '0;
      shift_reg <= '0;
    end else if (start_word) begin
      bit_count <= '0;
    end else if (shift_en) begin
      bit_count <= bit_count + 1'b1;
      shift_reg <= word[WIDTH-2:0];
    end
  end

`ifdef AUDIO_RX_MONO_MIX_EN
  logic [WIDTH-1:0] left_word;
  logic [WIDTH:0]   mix_sum;

  assign mix_sum = {left_word[WIDTH-1], left_word} + {word[WIDTH-1], word};

  // Keep the most recent completed left word for the mix
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      left_word <= '0;
    end else if (word_done && !channel) begin
      left_word <= word;
    end
  end

  // Right completion publishes the floor-average of left and right
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Signal_in    <= '0;
      Sample_valid <= 1'b0;
      Frame_err    <= 1'b0;
    end else begin
      Sample_valid <= word_done && channel;
      Frame_err    <= short_err;
      if (word_done && channel) begin
        Signal_in <= mix_sum[WIDTH:1];
      end
    end
  end
`else
  localparam logic CHAN_SEL = (CHANNEL != 0);

  // Publish completed words of the selected channel only
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Signal_in    <= '0;
      Sample_valid <= 1'b0;
      Frame_err    <= 1'b0;
    end else begin
      Sample_valid <= word_done && (channel == CHAN_SEL);
      Frame_err    <= short_err;
      if (word_done && (channel == CHAN_SEL)) begin
        Signal_in <= word;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Testbench for audio_adc_rx: drives I2S half-frames and compares the sample
// stream and error pulses against a half-frame level reference model.
module tb_audio_adc_rx;

  localparam int W  = 16;
  localparam int CH = 0;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b1;
  logic         AUD_BCLK = 1'b0;
  logic         AUD_ADCLRCK = 1'b0;
  logic         AUD_ADCDAT = 1'b0;
  logic [W-1:0] Signal_in;
  logic         Sample_valid;
  logic         Frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int consec = 0;
  logic last_valid = 1'b0;

  logic [W-1:0] exp_val[$];
  logic [W-1:0] obs_val[$];
  int exp_cyc[$];
  int obs_cyc[$];
  int exp_err[$];
  int obs_err[$];

  // reference model state: half-frame bookkeeping
  bit           m_active = 1'b0;
  int           m_n = 0;
  logic         m_ch = 1'b0;
  logic [W-1:0] m_left = '0;

  audio_adc_rx #(.WIDTH(W), .CHANNEL(CH)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT),
    .Signal_in(Signal_in),
    .Sample_valid(Sample_valid),
    .Frame_err(Frame_err)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // record every observed pulse with the cycle it was seen in
  always @(negedge Clk) begin
    if (Sample_valid) begin
      obs_val.push_back(Signal_in);
      obs_cyc.push_back(cyc);
      if (last_valid) consec++;
    end
    if (Frame_err) obs_err.push_back(cyc);
    last_valid = Sample_valid;
  end

  task automatic model_reset();
    m_active = 1'b0;
    m_n = 0;
    m_ch = 1'b0;
    m_left = '0;
  endtask

  // a word finished: decide what the downstream stage should see
  task automatic model_complete(input logic ch, input logic [W-1:0] w, input int c);
`ifdef AUDIO_RX_MONO_MIX_EN
    int s;
    if (!ch) begin
      m_left = w;
    end else begin
      s = int'($signed(m_left)) + int'($signed(w));
      exp_val.push_back(W'(s >>> 1));
      exp_cyc.push_back(c);
    end
`else
    if (ch == (CH != 0)) begin
      exp_val.push_back(w);
      exp_cyc.push_back(c);
    end
`endif
  endtask

  // an LRCK change closes the previous half-frame; short ones are errors
  task automatic model_edge(input bit is_edge, input logic ch, input int c);
    if (is_edge) begin
      if (m_active && m_n >= 1 && m_n <= W) exp_err.push_back(c + 3);
      m_active = 1'b1;
      m_n = 0;
      m_ch = ch;
    end
  endtask

  // one half-frame: n BCLK rises; rise 0 is the I2S delay bit, rises 1..W carry w MSB first
  task automatic send_half(input logic ch, input int n, input logic [W-1:0] w, input bit simul);
    bit is_edge;
    int c;
    is_edge = (ch != AUD_ADCLRCK);
    @(negedge Clk);
    if (simul) begin
      AUD_BCLK = 1'b0;
      AUD_ADCDAT = ~w[W-1];
      repeat (4) @(negedge Clk);
      AUD_ADCLRCK = ch;
      AUD_BCLK = 1'b1;
      model_edge(is_edge, ch, cyc);
      repeat (4) @(negedge Clk);
    end
    for (int i = 0; i < n; i++) begin
      AUD_BCLK = 1'b0;
      if (i == 0) AUD_ADCDAT = ~w[W-1];
      else if (i <= W) AUD_ADCDAT = w[W-i];
      else AUD_ADCDAT = 1'($urandom);
      if (i == 0 && !simul) begin
        AUD_ADCLRCK = ch;
        model_edge(is_edge, ch, cyc);
      end
      repeat (4) @(negedge Clk);
      AUD_BCLK = 1'b1;
      c = cyc;
      m_n++;
      if (m_active && m_n == W + 1) model_complete(m_ch, w, c + 3);
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic flush_and_clear_prep();
    repeat (12) @(negedge Clk);
  endtask

  task automatic clear_queues();
    exp_val.delete(); obs_val.delete();
    exp_cyc.delete(); obs_cyc.delete();
    exp_err.delete(); obs_err.delete();
  endtask

  task automatic test_reset();
    #5 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (Signal_in !== '0) begin bad++; $display("FAIL reset_signal: got %h want 0000", Signal_in); end
    total++; if (Sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Sample_valid); end
    total++; if (Frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", Frame_err); end
    Reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_left_capture();
    send_half(1'b1, 20, 16'hfa8d, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_half(1'b0, 20, 16'h4af3, 1'b0);
      send_half(1'b1, 20, 16'hfa8d, 1'b0);
    end
    flush_and_clear_prep();
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL left_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL left_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL left_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    total++; if (obs_err.size() !== exp_err.size()) begin bad++; $display("FAIL left_errcount: got %0d want %0d", obs_err.size(), exp_err.size()); end
    clear_queues();
  endtask

  task automatic test_sign_order();
    send_half(1'b0, 20, 16'h8001, 1'b0);
    send_half(1'b1, 20, 16'h1357, 1'b0);
    send_half(1'b0, 20, 16'h0005, 1'b0);
    send_half(1'b1, 20, 16'hc0de, 1'b0);
    flush_and_clear_prep();
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL sign_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL sign_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL sign_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    clear_queues();
  endtask

  task automatic test_short_half();
    send_half(1'b0, 10, 16'hbeef, 1'b0);
    send_half(1'b1, 20, 16'h2222, 1'b0);
    send_half(1'b0, 20, 16'h6a5c, 1'b0);
    send_half(1'b1, 20, 16'h3333, 1'b0);
    flush_and_clear_prep();
    total++; if (obs_err.size() !== exp_err.size()) begin bad++; $display("FAIL short_errcount: got %0d want %0d", obs_err.size(), exp_err.size()); end
    foreach (exp_err[i]) if (i < obs_err.size()) begin
      total++; if (obs_err[i] !== exp_err[i]) begin bad++; $display("FAIL short_errcycle[%0d]: got %0d want %0d", i, obs_err[i], exp_err[i]); end
    end
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL short_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL short_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    clear_queues();
  endtask

  task automatic test_simultaneous();
    send_half(1'b0, 24, 16'h9c31, 1'b1);
    send_half(1'b1, 24, 16'h0f0f, 1'b1);
    flush_and_clear_prep();
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL simul_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL simul_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL simul_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    total++; if (obs_err.size() !== exp_err.size()) begin bad++; $display("FAIL simul_errcount: got %0d want %0d", obs_err.size(), exp_err.size()); end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 24; k++) begin
      if (k == 23 || $urandom_range(0, 3) != 0) n = $urandom_range(W + 1, W + 12);
      else n = $urandom_range(1, W);
      send_half(1'(k % 2), n, W'($urandom), ($urandom_range(0, 3) == 0));
    end
    flush_and_clear_prep();
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL rand_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL rand_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    total++; if (obs_err.size() !== exp_err.size()) begin bad++; $display("FAIL rand_errcount: got %0d want %0d", obs_err.size(), exp_err.size()); end
    foreach (exp_err[i]) if (i < obs_err.size()) begin
      total++; if (obs_err[i] !== exp_err[i]) begin bad++; $display("FAIL rand_errcycle[%0d]: got %0d want %0d", i, obs_err[i], exp_err[i]); end
    end
    total++; if (consec !== 0) begin bad++; $display("FAIL rand_consecutive_valid: got %0d want 0", consec); end
    clear_queues();
  endtask

  task automatic test_reset_mid_word();
    send_half(1'b0, 20, 16'h1234, 1'b0);
    send_half(1'b1, 20, 16'h4321, 1'b0);
    send_half(1'b0, 8, 16'hffff, 1'b0);
    #3 Reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (Signal_in !== '0) begin bad++; $display("FAIL midreset_signal: got %h want 0000", Signal_in); end
    total++; if (Sample_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", Sample_valid); end
    total++; if (Frame_err !== 1'b0) begin bad++; $display("FAIL midreset_err: got %b want 0", Frame_err); end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    send_half(1'b0, 9, 16'hffff, 1'b0);
    send_half(1'b1, 20, 16'h7777, 1'b0);
    send_half(1'b0, 20, 16'h5a5a, 1'b0);
    send_half(1'b1, 20, 16'h0101, 1'b0);
    flush_and_clear_prep();
    total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL midreset_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL midreset_value[%0d]: got %h want %h", i, obs_val[i], exp_val[i]); end
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL midreset_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    total++; if (obs_err.size() !== exp_err.size()) begin bad++; $display("FAIL midreset_errcount: got %0d want %0d", obs_err.size(), exp_err.size()); end
    clear_queues();
  endtask

`ifdef AUDIO_RX_MONO_MIX_EN
  task automatic test_mono_mix();
    send_half(1'b0, 20, 16'h7fff, 1'b0);
    send_half(1'b1, 20, 16'h7fff, 1'b0);
    send_half(1'b0, 20, 16'h0005, 1'b0);
    send_half(1'b1, 20, 16'hfa8d, 1'b0);
    flush_and_clear_prep();
    total++; if (obs_val.size() !== 2) begin bad++; $display("FAIL mix_count: got %0d want 2", obs_val.size()); end
    if (obs_val.size() >= 2) begin
      total++; if (obs_val[0] !== 16'h7fff) begin bad++; $display("FAIL mix_max: got %h want 7fff", obs_val[0]); end
      total++; if (obs_val[1] !== 16'hfd49) begin bad++; $display("FAIL mix_neg: got %h want fd49", obs_val[1]); end
    end
    foreach (exp_val[i]) if (i < obs_val.size()) begin
      total++; if (obs_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL mix_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    clear_queues();
  endtask
`endif

  initial begin
    test_reset();
    test_left_capture();
    test_sign_order();
    test_short_half();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_word();
`ifdef AUDIO_RX_MONO_MIX_EN
    test_mono_mix();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
